// File: rtl/bridge_pkg.sv
// Shared constants, FSM state type and ASCII-hex helpers for the UART bridge host.
package bridge_pkg;

   localparam logic [7:0] PREAMBLE = 8'h4D;
   localparam logic [7:0] CR       = 8'h0D;
   localparam logic [7:0] LF       = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_RESP,
      ST_DONE
   } state_t;

   function automatic logic [7:0] hex_encode(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   // Returns {valid, nibble}; only uppercase A-F is accepted.
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
      if (b >= 8'h41 && b <= 8'h46) return {1'b1, b[3:0] + 4'd9};
      return 5'd0;
   endfunction

endpackage

// File: rtl/bridge_host_resp_parser.sv
// Parses the "M" + 4 hex digits + CR/LF read response; data_valid/err flag the deciding byte.
module bridge_host_resp_parser
   import bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] data,
   output logic        data_valid,
   output logic        err
);

   logic [2:0]  phase_reg, phase_next;
   logic [15:0] shift_reg, shift_next;
   logic [4:0]  dec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg <= 3'd0;
         shift_reg <= 16'h0000;
      end else begin
         phase_reg <= phase_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      phase_next = phase_reg;
      shift_next = shift_reg;
      data_valid = 1'b0;
      err        = 1'b0;
      dec        = hex_decode(rx_data);
      if (clear) begin
         phase_next = 3'd0;
      end else if (enable && rx_valid) begin
         case (phase_reg)
            3'd0: begin
               // Stray line endings ahead of the preamble are tolerated.
               if (rx_data == PREAMBLE) phase_next = 3'd1;
               else if (rx_data != CR && rx_data != LF) err = 1'b1;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
               if (dec[4]) begin
                  shift_next = {shift_reg[11:0], dec[3:0]};
                  phase_next = phase_reg + 3'd1;
               end else begin
                  err = 1'b1;
               end
            end
            default: begin
               if (rx_data == CR || rx_data == LF) data_valid = 1'b1;
               else err = 1'b1;
            end
         endcase
      end
   end

   assign data = shift_reg;

endmodule

// File: rtl/bridge_host.sv
// UART bridge bus initiator: serializes 16-bit reads/writes as ASCII hex and parses read replies.
// Optional read-response timeout enabled by defining BRIDGE_HOST_TIMEOUT_EN.
module bridge_host
   import bridge_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 16,
   parameter int          DATA_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  rw_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rdata_valid_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [7:0]            tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_valid_i
);

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [DATA_WIDTH-1:0]   wdata_reg;
   logic                    rw_reg;
   logic [3:0]              byte_idx_reg;
   logic [DATA_WIDTH-1:0]   rdata_reg;
   logic                    rdata_valid_reg;
   logic                    error_reg;

   logic                    xfer, last_byte, timeout_hit;
   logic [3:0]              last_idx;
   logic [31:0]             nib_shift;
   logic [7:0]              tx_byte;
   logic [15:0]             p_data;
   logic                    p_valid, p_err;

   assign xfer      = (state_reg == ST_SEND) && tx_ready_i;
   assign last_idx  = rw_reg ? 4'd10 : 4'd6;
   assign last_byte = (byte_idx_reg == last_idx);
   // Address then data nibbles, MSB first, for byte indices 1..8.
   assign nib_shift = {addr_reg, wdata_reg} << {byte_idx_reg - 4'd1, 2'b00};

   always_comb begin
      tx_byte = PREAMBLE;
      if (byte_idx_reg == 4'd0)                tx_byte = PREAMBLE;
      else if (byte_idx_reg == last_idx)        tx_byte = LF;
      else if (byte_idx_reg == last_idx - 4'd1) tx_byte = CR;
      else                                      tx_byte = hex_encode(nib_shift[31:28]);
   end

   bridge_host_resp_parser u_parser (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (xfer && last_byte && !rw_reg),
      .enable     (state_reg == ST_WAIT_RESP),
      .rx_data    (rx_data_i),
      .rx_valid   (rx_valid_i),
      .data       (p_data),
      .data_valid (p_valid),
      .err        (p_err)
   );

`ifdef BRIDGE_HOST_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] to_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_cnt_reg <= 32'd0;
      else if (state_reg != ST_WAIT_RESP || rx_valid_i) to_cnt_reg <= 32'd0;
      else to_cnt_reg <= to_cnt_reg + 32'd1;
   end

   assign timeout_hit = (state_reg == ST_WAIT_RESP) && !rx_valid_i && (to_cnt_reg == TIMEOUT_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:      if (valid_i) state_next = ST_SEND;
         ST_SEND:      if (xfer && last_byte) state_next = rw_reg ? ST_DONE : ST_WAIT_RESP;
         ST_WAIT_RESP: if (p_valid || p_err || timeout_hit) state_next = ST_DONE;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg        <= '0;
         wdata_reg       <= '0;
         rw_reg          <= 1'b0;
         byte_idx_reg    <= 4'd0;
         rdata_reg       <= '0;
         rdata_valid_reg <= 1'b0;
         error_reg       <= 1'b0;
      end else begin
         if (state_reg == ST_IDLE && valid_i) begin
            addr_reg     <= addr_i;
            wdata_reg    <= wdata_i;
            rw_reg       <= rw_i;
            byte_idx_reg <= 4'd0;
         end else if (xfer) begin
            byte_idx_reg <= byte_idx_reg + 4'd1;
         end
         if (state_reg == ST_WAIT_RESP && p_valid) rdata_reg <= p_data;
         rdata_valid_reg <= (state_reg == ST_WAIT_RESP) && p_valid;
         error_reg       <= (state_reg == ST_WAIT_RESP) && !p_valid && (p_err || timeout_hit);
      end
   end

   assign ready_o       = (state_reg == ST_IDLE);
   assign tx_valid_o    = (state_reg == ST_SEND);
   assign tx_data_o     = tx_valid_o ? tx_byte : 8'h00;
   assign done_o        = (state_reg == ST_DONE);
   assign rdata_o       = rdata_reg;
   assign rdata_valid_o = rdata_valid_reg;
   assign error_o       = error_reg;

endmodule

// File: tb/tb_bridge_host.sv
// Directed bench for bridge_host: write/read streams, back-pressure, bad response, reset abort, timeout.
module tb_bridge_host;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] addr_i = '0, wdata_i = '0;
   logic        rw_i = 1'b0, valid_i = 1'b0;
   logic        ready_o;
   logic [15:0] rdata_o;
   logic        rdata_valid_o, done_o, error_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b1;
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] got [0:15];
   int         cnt;

   always #5 clk = ~clk;

   bridge_host #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .wdata_i(wdata_i), .rw_i(rw_i),
      .valid_i(valid_i), .ready_o(ready_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .done_o(done_o), .error_o(error_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
      .tx_ready_i(tx_ready_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s miscompare", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic rw, input logic [15:0] a, input logic [15:0] d);
      rw_i = rw; addr_i = a; wdata_i = d; valid_i = 1'b1;
      #1;
      check("req_ready", {31'd0, ready_o}, 32'd1);
      tick();
      valid_i = 1'b0;
   endtask

   // Collects n transferred bytes; optional 1-in-3 ready pattern with hold and ready_o checks.
   task automatic run_tx(input int n, input bit stall);
      logic       stalled_prev = 1'b0;
      logic [7:0] prev_data = 8'h00;
      cnt = 0;
      for (int cyc = 0; cyc < 200 && cnt < n; cyc++) begin
         tx_ready_i = stall ? (cyc % 3 == 2) : 1'b1;
         #1;
         if (stall) check("ready_busy", {31'd0, ready_o}, 32'd0);
         if (tx_valid_o) begin
            if (stalled_prev) check("tx_hold", {24'd0, tx_data_o}, {24'd0, prev_data});
            if (tx_ready_i) begin
               got[cnt] = tx_data_o;
               cnt++;
            end
         end
         stalled_prev = tx_valid_o && !tx_ready_i;
         prev_data    = tx_data_o;
         tick();
      end
      tx_ready_i = 1'b1;
      check("tx_count", cnt, n);
   endtask

   task automatic feed(input logic [7:0] b);
      rx_data_i = b; rx_valid_i = 1'b1;
      tick();
      rx_valid_i = 1'b0;
   endtask

   logic [7:0] wr_exp [0:10] = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h36, 8'h30, 8'h30, 8'h41, 8'h35, 8'h0D, 8'h0A};
   logic [7:0] rd_exp [0:6]  = '{8'h4D, 8'h30, 8'h30, 8'h31, 8'h43, 8'h0D, 8'h0A};
   logic [7:0] rd2_exp [0:6] = '{8'h4D, 8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A};

   initial begin
      // Reset state
      #12;
      check("rst_ready", {31'd0, ready_o}, 32'd1);
      check("rst_txv", {31'd0, tx_valid_o}, 32'd0);
      check("rst_txd", {24'd0, tx_data_o}, 32'd0);
      check("rst_rdata", {16'd0, rdata_o}, 32'd0);
      check("rst_pulses", {29'd0, rdata_valid_o, done_o, error_o}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // Write 0x0006 <- 0x00A5, no back-pressure
      request(1'b1, 16'h0006, 16'h00A5);
      run_tx(11, 1'b0);
      for (int i = 0; i < 11; i++) check($sformatf("wr_byte%0d", i), {24'd0, got[i]}, {24'd0, wr_exp[i]});
      check("wr_done", {31'd0, done_o}, 32'd1);
      check("wr_no_rdv", {31'd0, rdata_valid_o}, 32'd0);
      check("wr_ready_in_done", {31'd0, ready_o}, 32'd0);
      tick();
      check("wr_ready_after", {31'd0, ready_o}, 32'd1);
      check("wr_done_cleared", {31'd0, done_o}, 32'd0);

      // Read 0x001C, response BEEF
      request(1'b0, 16'h001C, 16'h0000);
      run_tx(7, 1'b0);
      for (int i = 0; i < 7; i++) check($sformatf("rd_byte%0d", i), {24'd0, got[i]}, {24'd0, rd_exp[i]});
      feed(8'h4D); feed(8'h42); feed(8'h45); feed(8'h45); feed(8'h46);
      check("rd_not_done_early", {31'd0, done_o}, 32'd0);
      feed(8'h0D);
      check("rd_rdata", {16'd0, rdata_o}, 32'h0000BEEF);
      check("rd_rdv", {31'd0, rdata_valid_o}, 32'd1);
      check("rd_done", {31'd0, done_o}, 32'd1);
      check("rd_no_err", {31'd0, error_o}, 32'd0);
      feed(8'h0A);
      check("rd_lf_idle", {30'd0, ready_o, done_o}, 32'd2);

      // Write with 1-in-3 ready
      request(1'b1, 16'h0006, 16'h00A5);
      run_tx(11, 1'b1);
      for (int i = 0; i < 11; i++) check($sformatf("st_byte%0d", i), {24'd0, got[i]}, {24'd0, wr_exp[i]});
      check("st_done", {31'd0, done_o}, 32'd1);
      tick();

      // Read with malformed response (leading LF ignored, then M 1 G)
      request(1'b0, 16'h00FF, 16'h0000);
      run_tx(7, 1'b0);
      for (int i = 0; i < 7; i++) check($sformatf("er_byte%0d", i), {24'd0, got[i]}, {24'd0, rd2_exp[i]});
      feed(8'h0A);
      check("er_lf_ignored", {31'd0, error_o | done_o}, 32'd0);
      feed(8'h4D); feed(8'h31); feed(8'h47);
      check("er_error", {31'd0, error_o}, 32'd1);
      check("er_done", {31'd0, done_o}, 32'd1);
      check("er_no_rdv", {31'd0, rdata_valid_o}, 32'd0);
      check("er_rdata_kept", {16'd0, rdata_o}, 32'h0000BEEF);
      tick();
      check("er_ready", {31'd0, ready_o}, 32'd1);
      check("er_err_cleared", {31'd0, error_o}, 32'd0);

      // Reset after 3 write bytes
      request(1'b1, 16'h1234, 16'h5678);
      run_tx(3, 1'b0);
      check("ab_mid_txv", {31'd0, tx_valid_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("ab_txv", {31'd0, tx_valid_o}, 32'd0);
      check("ab_ready", {31'd0, ready_o}, 32'd1);
      check("ab_txd", {24'd0, tx_data_o}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      request(1'b0, 16'h001C, 16'h0000);
      run_tx(7, 1'b0);
      for (int i = 0; i < 7; i++) check($sformatf("ab_byte%0d", i), {24'd0, got[i]}, {24'd0, rd_exp[i]});
      feed(8'h4D); feed(8'h30); feed(8'h30); feed(8'h30); feed(8'h31); feed(8'h0A);
      check("ab_rdata_lf", {16'd0, rdata_o}, 32'h00000001);
      check("ab_rdv", {30'd0, rdata_valid_o, done_o}, 32'd3);
      tick();

`ifdef BRIDGE_HOST_TIMEOUT_EN
      // Timeout: no response, error 50 cycles after entering WAIT_RESP
      request(1'b0, 16'h001C, 16'h0000);
      run_tx(7, 1'b0);
      begin
         int k;
         for (k = 1; k <= 200; k++) begin
            tick();
            if (error_o) break;
         end
         check("to_cycles", k, 50);
      end
      check("to_done", {31'd0, done_o}, 32'd1);
      check("to_rdata_kept", {16'd0, rdata_o}, 32'h00000001);
      tick();
      check("to_ready", {31'd0, ready_o}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bridge_host.md
Name: bridge_host

Overview:
- Host-side bus initiator for the UART bridge protocol, i.e. the opposite end of the in-FPGA bridge.
- Accepts 16-bit register read/write requests and serializes each one as an ASCII-hex command byte stream toward a UART transmitter.
- For reads, parses the returned "M" + 4 hex digits + CR LF response and presents it as 16-bit read data.
- Sits between a local test sequencer or controller and a uart_tx/rx_uart pair, so one FPGA can drive a remote manta core set.

Parameters:
- ADDR_WIDTH, 16, request address width; fixed at 16, other values unsupported.
- DATA_WIDTH, 16, request write/read data width; fixed at 16.
- TIMEOUT_CYCLES, 1000000, read-response timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr_i  in  16  request address
- wdata_i  in  16  request write data
- rw_i  in  1  1 = write, 0 = read
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i && ready_o
- rdata_o  out  16  read data, held until the next read completes
- rdata_valid_o  out  1  one-cycle pulse: rdata_o updated
- done_o  out  1  one-cycle pulse: request finished (write sent, or read response received)
- error_o  out  1  one-cycle pulse: malformed response or timeout
- tx_data_o  out  8  byte toward uart_tx
- tx_valid_o  out  1  byte valid
- tx_ready_i  in  1  uart_tx can take byte; transfer on tx_valid_o && tx_ready_i
- rx_data_i  in  8  byte from rx_uart
- rx_valid_i  in  1  one-cycle byte strobe

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: ready_o=1, tx_valid_o=0, tx_data_o=0, rdata_o=0, rdata_valid_o=0, done_o=0, error_o=0; FSM in IDLE.
- Reset mid-operation aborts the transaction immediately; no partial bytes are resumed.
- FSM states:
  - IDLE: ready_o=1. On accept, latch addr/wdata/rw, ready_o<=0, byte_idx<=0, go SEND.
  - SEND: tx_valid_o=1. tx_data_o selected by byte_idx from the latched values.
    - Read sequence, 7 bytes: 0x4D, a[15:12], a[11:8], a[7:4], a[3:0], 0x0D, 0x0A.
    - Write sequence, 11 bytes: 0x4D, 4 address nibbles, 4 data nibbles MSB first, 0x0D, 0x0A.
    - Nibble encoding: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase only).
    - byte_idx advances only on a transfer.
    - After the final LF transfer: writes go DONE; reads go WAIT_RESP with the parser cleared.
  - WAIT_RESP: parses rx_valid_i bytes.
    - Expect 0x4D; LF/CR before the preamble are ignored; any other byte -> error.
    - Then 4 hex digits, shifted in MSB first; a non-hex digit -> error.
    - Then CR or LF -> rdata_o<=assembled value, rdata_valid_o pulse, go DONE. Any other byte -> error.
    - The trailing LF after CR arrives in IDLE and is ignored.
  - DONE: done_o pulse for one cycle, next state IDLE (ready_o=1 the cycle after).
  - Error: error_o pulse, done_o pulse, rdata_o unchanged, go IDLE.
- rx bytes arriving outside WAIT_RESP are discarded.
- No back-to-back overlap: at most one outstanding request.
- Minimum write latency: 11 transfer cycles + 1 (DONE).

Optional Feature:
- Macro BRIDGE_HOST_TIMEOUT_EN.
- Defined: a 32-bit counter runs in WAIT_RESP and resets on every rx_valid_i. Reaching TIMEOUT_CYCLES-1 causes an error exit (error_o + done_o pulse, go IDLE).
- Undefined: no counter; WAIT_RESP waits indefinitely, and only reset escapes.

Decomposition:
- Package bridge_pkg: localparams PREAMBLE=8'h4D, CR=8'h0D, LF=8'h0A; the FSM state enum typedef; functions hex_encode(4b->8b) and hex_decode(8b->{valid,4b}).
- One sub-module, bridge_host_resp_parser: the WAIT_RESP byte parser. Inputs are clear/enable plus the rx stream; outputs are data, data_valid and err.

Test Plan:
- Write addr=0x0006 wdata=0x00A5, tx_ready_i=1 constant -> tx bytes 4D 30 30 30 36 30 30 41 35 0D 0A, done_o one cycle after the last transfer, no rdata_valid_o.
- Read addr=0x001C, then feed rx "M","B","E","E","F",CR,LF -> tx bytes 4D 30 30 31 43 0D 0A; rdata_o=0xBEEF, rdata_valid_o and done_o pulse on the CR cycle.
- tx_ready_i toggled 1-in-3 during a write -> identical 11-byte stream, tx_data_o stable while tx_valid_o && !tx_ready_i, ready_o=0 throughout.
- Read, response "M","1","G" -> error_o pulse on the "G" byte, rdata_o keeps its previous value, ready_o=1 afterwards.
- rst_n asserted after 3 bytes of a write -> tx_valid_o=0 and ready_o=1 immediately; a new read then starts from byte 0x4D.
- With BRIDGE_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=50: read with no response -> error_o pulse exactly 50 cycles after entering WAIT_RESP.
